fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of the CPU: owns the PC register, issues word reads to
//  instruction memory over a req/gnt + rvalid handshake and buffers returned words.
//  Presents instr/instr_pc with valid/ready to decode (control unit + sign_extend).
//  Takes the branch/jump redirect back from execute as PCsrc plus the sign-extended ImmOp.
// PARAMETERS
//  ADDRESS_WIDTH  32            PC / memory address width
//  DATA_WIDTH     32            instruction word width
//  RESET_PC       32'hBFC00000  first fetch address after reset
// PORTS
//  clk          in   1    clock, all state on rising edge
//  rst_n        in   1    asynchronous active-low reset
//  imem_req     out  1    read request to instruction memory
//  imem_addr    out  AW   word-aligned fetch address
//  imem_gnt     in   1    request accepted when imem_req & imem_gnt
//  imem_rvalid  in   1    read data valid, one per accepted request, in order
//  imem_rdata   in   DW   returned instruction word
//  instr_valid  out  1    buffered instruction available to decode
//  instr        out  DW   instruction at FIFO head
//  instr_pc     out  AW   PC of instr
//  instr_ready  in   1    decode consumes head when instr_valid & instr_ready
//  PCsrc        in   1    take redirect, sampled only on a consume cycle
//  ImmOp        in   AW   PC-relative offset; target = instr_pc + ImmOp
//  misalign_err out  1    sticky misaligned-target flag (MISALIGN_TRAP_EN only)
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_PC, FIFO empty, outstanding=0, drop=0,
//    imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, misalign_err=0.
//  - FIFO: 2 entries {instr, pc}; instr/instr_pc driven from head, instr_valid = count!=0.
//  - Issue: imem_req=1 when outstanding==0 and count<2 and not halted; imem_addr=pc.
//    Once raised, req and addr hold until gnt (except redirect retarget, below).
//  - Accept (req&gnt): outstanding<=1, inflight_pc<=pc, pc<=pc+4 (wraps mod 2^AW).
//    At most one outstanding request; next req no earlier than cycle after rvalid.
//  - Response (rvalid): outstanding<=0; if drop: discard word, drop<=0; else push
//    {imem_rdata, inflight_pc}. Earliest instr_valid = 1 cycle after rvalid.
//  - Push and pop same cycle with count==2 cannot occur (issue rule); count==1 push+pop
//    keeps count=1.
//  - rvalid with outstanding==0: protocol error, ignored (bench assertion).
//  - Redirect = instr_valid & instr_ready & PCsrc:
//    * target = instr_pc + ImmOp, truncated to AW; pc<=target next cycle.
//    * FIFO flushed (includes entry behind head); the consumed head is still delivered.
//    * outstanding & no rvalid this cycle -> drop<=1 (response discarded later).
//    * rvalid same cycle -> that word discarded, not pushed.
//    * req&gnt same cycle -> accepted; drop<=1, pc<=target (not +4).
//    * req pending, no gnt -> imem_addr retargets to target next cycle, req stays high.
//  - Latency, no stalls: gnt same cycle, rvalid next -> instr_valid 2 cycles after req.
//  - rst_n asserted mid-transfer: all state cleared; late rvalid after reset is ignored.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: redirect with target[1:0]!=0 sets misalign_err (sticky
//    until reset), flushes FIFO, halts issue; instr_valid stays 0.
//  MISALIGN_TRAP_EN undefined: target[1:0] forced to 2'b00, fetch continues;
//    misalign_err port tied 0.
// TESTING
//  1 Reset release, gnt=1, rvalid 1 cycle later -> addrs BFC00000,BFC00004,.. in order;
//    instr_pc matches.
//  2 instr_ready=0 for 10 cycles -> count saturates at 2, imem_req low, no word lost;
//    release -> in-order drain.
//  3 Consume at instr_pc=BFC00008, PCsrc=1, ImmOp=-8 (FFFFFFF8) with req in flight
//    -> stale word dropped; next instr_pc=BFC00000.
//  4 Redirect same cycle as rvalid, and same cycle as req&gnt -> neither word reaches
//    decode; first delivered pc = target.
//  5 pc=FFFFFFFC sequential -> next imem_addr=00000000.
//  6 MISALIGN_TRAP_EN: ImmOp=2 redirect -> misalign_err=1, imem_req stays 0; without
//    macro -> fetch at target&~3.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC and issues single-outstanding word reads to instruction memory.
// It buffers returned words in a 2-entry FIFO and handles PC-relative redirects (optional MISALIGN_TRAP_EN).
module fetch_unit #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = 32'hBFC0_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     instr_valid,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  input  logic                     instr_ready,
  input  logic                     PCsrc,
  input  logic [ADDRESS_WIDTH-1:0] ImmOp,
  output logic                     misalign_err
);

  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(4);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = {{(ADDRESS_WIDTH-2){1'b1}}, 2'b00};

  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [ADDRESS_WIDTH-1:0] r_inflight_pc;
  logic                     r_out;
  logic                     r_drop;
  logic                     r_req;
  logic                     r_hv;
  logic [DATA_WIDTH-1:0]    r_h_instr;
  logic [ADDRESS_WIDTH-1:0] r_h_pc;
  logic                     r_tv;
  logic [DATA_WIDTH-1:0]    r_t_instr;
  logic [ADDRESS_WIDTH-1:0] r_t_pc;

  logic                     w_accept;
  logic                     w_resp;
  logic                     w_pop;
  logic                     w_redir;
  logic                     w_push;
  logic [ADDRESS_WIDTH-1:0] w_sum;
  logic [ADDRESS_WIDTH-1:0] w_target;
  logic                     w_trap;
  logic                     w_halted;

  logic [ADDRESS_WIDTH-1:0] w_pc_n;
  logic [ADDRESS_WIDTH-1:0] w_inflight_n;
  logic                     w_out_n;
  logic                     w_drop_n;
  logic                     w_req_n;
  logic                     w_halt_n;
  logic                     w_hv_n;
  logic [DATA_WIDTH-1:0]    w_hi_n;
  logic [ADDRESS_WIDTH-1:0] w_hp_n;
  logic                     w_tv_n;
  logic [DATA_WIDTH-1:0]    w_ti_n;
  logic [ADDRESS_WIDTH-1:0] w_tp_n;

  assign w_accept = r_req & imem_gnt;
  // A response with nothing outstanding (e.g. left over from before a reset) is ignored.
  assign w_resp   = imem_rvalid & r_out;
  assign w_pop    = r_hv & instr_ready;
  assign w_redir  = w_pop & PCsrc;
  assign w_push   = w_resp & ~r_drop & ~w_redir;
  assign w_sum    = r_h_pc + ImmOp;

`ifdef MISALIGN_TRAP_EN
  logic r_halt;
  logic r_mis;

  assign w_target     = w_sum;
  assign w_trap       = w_redir & (w_sum[1:0] != 2'b00);
  assign w_halted     = r_halt;
  assign misalign_err = r_mis;

  // Sticky trap state: set by a misaligned redirect, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halt <= 1'b0;
      r_mis  <= 1'b0;
    end else begin
      r_halt <= w_halt_n;
      r_mis  <= r_mis | w_trap;
    end
  end
`else
  assign w_target     = w_sum & ALIGN_MASK;
  assign w_trap       = 1'b0;
  assign w_halted     = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // PC, outstanding-request and drop bookkeeping.
  always_comb begin
    w_pc_n       = r_pc;
    w_inflight_n = r_inflight_pc;
    w_out_n      = r_out;
    w_drop_n     = r_drop;
    w_halt_n     = w_halted | w_trap;
    if (w_accept) begin
      w_out_n      = 1'b1;
      w_inflight_n = r_pc;
      w_pc_n       = r_pc + PC_STEP;
    end else begin
      w_inflight_n = r_inflight_pc;
    end
    if (w_resp) begin
      w_out_n  = 1'b0;
      w_drop_n = 1'b0;
    end else begin
      w_out_n = w_out_n;
    end
    // A redirect poisons whatever word is still to come back for the old stream.
    if (w_redir) begin
      w_pc_n = w_target;
      if (w_accept) begin
        w_drop_n = 1'b1;
      end else if (r_out && !imem_rvalid) begin
        w_drop_n = 1'b1;
      end else begin
        w_drop_n = w_drop_n;
      end
    end else begin
      w_pc_n = w_pc_n;
    end
  end

  // Two-entry shift FIFO: head feeds decode directly, tail only fills behind a held head.
  always_comb begin
    w_hv_n = r_hv;
    w_hi_n = r_h_instr;
    w_hp_n = r_h_pc;
    w_tv_n = r_tv;
    w_ti_n = r_t_instr;
    w_tp_n = r_t_pc;
    if (w_redir) begin
      w_hv_n = 1'b0;
      w_tv_n = 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b01: begin
          w_hv_n = r_tv;
          w_hi_n = r_t_instr;
          w_hp_n = r_t_pc;
          w_tv_n = 1'b0;
        end
        2'b10: begin
          if (!r_hv) begin
            w_hv_n = 1'b1;
            w_hi_n = imem_rdata;
            w_hp_n = r_inflight_pc;
          end else begin
            w_tv_n = 1'b1;
            w_ti_n = imem_rdata;
            w_tp_n = r_inflight_pc;
          end
        end
        2'b11: begin
          if (r_tv) begin
            w_hi_n = r_t_instr;
            w_hp_n = r_t_pc;
            w_ti_n = imem_rdata;
            w_tp_n = r_inflight_pc;
          end else begin
            w_hi_n = imem_rdata;
            w_hp_n = r_inflight_pc;
          end
        end
        default: begin
          w_hv_n = r_hv;
        end
      endcase
    end
    w_req_n = ~w_out_n & ~(w_hv_n & w_tv_n) & ~w_halt_n;
  end

  // State registers; every output below is taken straight from one of these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_inflight_pc <= {ADDRESS_WIDTH{1'b0}};
      r_out         <= 1'b0;
      r_drop        <= 1'b0;
      r_req         <= 1'b0;
      r_hv          <= 1'b0;
      r_h_instr     <= {DATA_WIDTH{1'b0}};
      r_h_pc        <= {ADDRESS_WIDTH{1'b0}};
      r_tv          <= 1'b0;
      r_t_instr     <= {DATA_WIDTH{1'b0}};
      r_t_pc        <= {ADDRESS_WIDTH{1'b0}};
    end else begin
      r_pc          <= w_pc_n;
      r_inflight_pc <= w_inflight_n;
      r_out         <= w_out_n;
      r_drop        <= w_drop_n;
      r_req         <= w_req_n;
      r_hv          <= w_hv_n;
      r_h_instr     <= w_hi_n;
      r_h_pc        <= w_hp_n;
      r_tv          <= w_tv_n;
      r_t_instr     <= w_ti_n;
      r_t_pc        <= w_tp_n;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_hv;
  assign instr       = r_h_instr;
  assign instr_pc    = r_h_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed redirect table, hand-built handshake corner
// cases, and randomized memory/decode traffic checked against a program-order PC model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic        misalign_err;

  fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .PCsrc(PCsrc), .ImmOp(ImmOp),
    .misalign_err(misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] from_pc;
    logic [31:0] imm;
    logic [31:0] exp_pc;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  // memory model state and knobs
  bit          manual;
  bit          gnt_always;
  int          lat_max;
  bit          m_pend;
  int          m_wait;
  logic [31:0] m_addr;

  // decode driver knobs
  int          cons_mode;
  logic [31:0] tgt_from;
  logic [31:0] tgt_imm;

  // program-order reference model
  logic [31:0] exp_pc;
  logic [31:0] last_pc;
  bit          halted;
  int          n_cons;
  int          redir_at;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  task automatic mem_auto();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (m_pend) begin
      chk("req_while_outstanding", {31'd0, imem_req}, 32'd0);
      if (m_wait == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(m_addr);
        m_pend      = 1'b0;
      end else begin
        m_wait--;
      end
    end else if (imem_req) begin
      if (gnt_always || ($urandom % 3 != 0)) begin
        imem_gnt = 1'b1;
        m_pend   = 1'b1;
        m_addr   = imem_addr;
        m_wait   = $urandom_range(0, lat_max);
      end
    end
  endtask

  task automatic cons_auto();
    int off;
    if (cons_mode == 1) begin
      instr_ready = ($urandom % 4 != 0);
      PCsrc       = ($urandom % 6 == 0);
      off         = $urandom_range(0, 63) - 32;
      ImmOp       = off * 4;
`ifndef MISALIGN_TRAP_EN
      if ($urandom % 4 == 0) ImmOp = ImmOp + $urandom_range(1, 3);
`endif
    end else if (cons_mode == 2) begin
      instr_ready = 1'b1;
      PCsrc       = instr_valid && (instr_pc == tgt_from);
      ImmOp       = tgt_imm;
    end
  endtask

  // One clock: check any consume in effect this cycle, then drive the next cycle's inputs.
  task automatic cycle();
    logic [31:0] t;
    @(negedge clk);
    if (rst_n && instr_valid && instr_ready) begin
      n_cons++;
      chk("deliver_after_trap", {31'd0, halted}, 32'd0);
      chk("cons_pc", instr_pc, exp_pc);
      chk("cons_instr", instr, mem_word(exp_pc));
      last_pc = instr_pc;
      if (PCsrc) begin
        redir_at = n_cons;
        t = exp_pc + ImmOp;
`ifdef MISALIGN_TRAP_EN
        if (t[1:0] != 2'b00) halted = 1'b1;
        else exp_pc = t;
`else
        exp_pc = t & 32'hFFFF_FFFC;
`endif
      end else begin
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    if (!manual) mem_auto();
    cons_auto();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = 32'd0;
    m_pend = 1'b0; exp_pc = RESET_PC; halted = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_cons(input string nm, input int need, input int budget);
    int base = n_cons;
    int k = 0;
    while (n_cons < base + need && k < budget) begin
      cycle();
      k++;
    end
    chk(nm, {31'd0, (n_cons >= base + need)}, 32'd1);
  endtask

  vec_t tbl [6];
  int   n_tbl;

  initial begin
    rst_n = 1'b0; manual = 1'b1; gnt_always = 1'b1; lat_max = 0; cons_mode = 0;
    m_pend = 1'b0; m_wait = 0; m_addr = 32'd0; tgt_from = 32'd1; tgt_imm = 32'd0;
    n_cons = 0; redir_at = -1; last_pc = 32'd0; halted = 1'b0; exp_pc = RESET_PC;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = 32'd0;

    tbl[0] = '{32'hBFC0_0008, 32'hFFFF_FFF8, 32'hBFC0_0000};
    tbl[1] = '{32'hBFC0_0004, 32'h0000_0010, 32'hBFC0_0014};
    tbl[2] = '{32'hBFC0_0018, 32'h403F_FFE0, 32'hFFFF_FFF8};
    tbl[3] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_0100};
    tbl[4] = '{32'h0000_0104, 32'hFFFF_FF00, 32'h0000_0004};
    tbl[5] = '{32'h0000_0008, 32'h0000_0006, 32'h0000_000C};
`ifdef MISALIGN_TRAP_EN
    n_tbl = 5;
`else
    n_tbl = 6;
`endif

    // Reset mid-transfer, then a late rvalid that must be ignored.
    do_reset();
    cycle();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
    imem_gnt = 1'b1; cycle(); imem_gnt = 1'b0;
    do_reset();
    cycle();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; cycle(); imem_rvalid = 1'b0;
    chk("late_rvalid_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_rvalid_req", {31'd0, imem_req}, 32'd1);
    chk("late_rvalid_addr", imem_addr, RESET_PC);

    // Latency: req+gnt, rvalid next cycle, instr_valid two cycles after req.
    imem_gnt = 1'b1; cycle(); imem_gnt = 1'b0;
    chk("lat_valid_t1", {31'd0, instr_valid}, 32'd0);
    chk("lat_req_t1", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = mem_word(RESET_PC); cycle(); imem_rvalid = 1'b0;
    chk("lat_valid_t2", {31'd0, instr_valid}, 32'd1);
    chk("lat_instr_pc", instr_pc, RESET_PC);
    chk("lat_instr", instr, mem_word(RESET_PC));
    chk("lat_next_addr", imem_addr, RESET_PC + 32'd4);

    // Redirect in the same cycle as rvalid: that word never reaches decode.
    imem_gnt = 1'b1; cycle(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = mem_word(RESET_PC + 32'd4);
    instr_ready = 1'b1; PCsrc = 1'b1; ImmOp = 32'h0000_0100;
    cycle();
    imem_rvalid = 1'b0; instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = 32'd0;
    chk("rv_redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("rv_redir_addr", imem_addr, 32'hBFC0_0100);
    chk("rv_redir_req", {31'd0, imem_req}, 32'd1);

    // Redirect in the same cycle as req&gnt: accepted word comes back and is dropped.
    imem_gnt = 1'b1; cycle(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = mem_word(32'hBFC0_0100); cycle(); imem_rvalid = 1'b0;
    chk("gnt_redir_head", instr_pc, 32'hBFC0_0100);
    imem_gnt = 1'b1; instr_ready = 1'b1; PCsrc = 1'b1; ImmOp = 32'hFFFF_FFC0;
    cycle();
    imem_gnt = 1'b0; instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = 32'd0;
    chk("gnt_redir_req_low", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = mem_word(32'hBFC0_0104); cycle(); imem_rvalid = 1'b0;
    chk("gnt_redir_dropped", {31'd0, instr_valid}, 32'd0);
    chk("gnt_redir_addr", imem_addr, 32'hBFC0_00C0);

    // Pending req without gnt retargets to the redirect target.
    imem_gnt = 1'b1; cycle(); imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = mem_word(32'hBFC0_00C0); cycle(); imem_rvalid = 1'b0;
    chk("retgt_pre_addr", imem_addr, 32'hBFC0_00C4);
    instr_ready = 1'b1; PCsrc = 1'b1; ImmOp = 32'h0000_0008;
    cycle();
    instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = 32'd0;
    chk("retgt_req", {31'd0, imem_req}, 32'd1);
    chk("retgt_addr", imem_addr, 32'hBFC0_00C8);
    manual = 1'b0; gnt_always = 1'b1; lat_max = 0; cons_mode = 2; tgt_from = 32'd1;
    wait_cons("retgt_drain", 1, 50);
    chk("retgt_first_pc", last_pc, 32'hBFC0_00C8);

    // Table of redirects, including the wrap from FFFFFFFC to 00000000.
    cons_mode = 0;
    do_reset();
    manual = 1'b0; gnt_always = 1'b0; lat_max = 2; cons_mode = 2;
    for (int i = 0; i < n_tbl; i++) begin
      int k = 0;
      tgt_from = tbl[i].from_pc;
      tgt_imm  = tbl[i].imm;
      redir_at = -1;
      while (!(redir_at >= 0 && n_cons > redir_at) && k < 400) begin
        cycle();
        k++;
      end
      chk($sformatf("tbl%0d_done", i), {31'd0, (redir_at >= 0 && n_cons > redir_at)}, 32'd1);
      chk($sformatf("tbl%0d_next_pc", i), last_pc, tbl[i].exp_pc);
    end

    // Decode stalled: buffer fills to two, req drops, then in-order drain.
    cons_mode = 0;
    do_reset();
    manual = 1'b0; gnt_always = 1'b1; lat_max = 0;
    repeat (10) cycle();
    chk("stall_req_low", {31'd0, imem_req}, 32'd0);
    chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    chk("stall_no_outstanding", {31'd0, m_pend}, 32'd0);
    cons_mode = 2; tgt_from = 32'd1;
    wait_cons("stall_drain", 4, 40);

    // Randomized memory timing and decode behaviour.
    cons_mode = 0;
    do_reset();
    manual = 1'b0; gnt_always = 1'b0; lat_max = 2; cons_mode = 1;
    repeat (3000) cycle();
    chk("rand_progress", {31'd0, (n_cons > 400)}, 32'd1);
    chk("rand_misalign", {31'd0, misalign_err}, 32'd0);

`ifdef MISALIGN_TRAP_EN
    cons_mode = 0;
    do_reset();
    manual = 1'b0; gnt_always = 1'b1; lat_max = 0; cons_mode = 2;
    tgt_from = RESET_PC + 32'd4; tgt_imm = 32'd2;
    repeat (20) cycle();
    chk("trap_err", {31'd0, misalign_err}, 32'd1);
    chk("trap_req", {31'd0, imem_req}, 32'd0);
    chk("trap_valid", {31'd0, instr_valid}, 32'd0);
    repeat (5) cycle();
    chk("trap_sticky", {31'd0, misalign_err}, 32'd1);
    chk("trap_req_hold", {31'd0, imem_req}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
